// File: rtl/matrix_scalar_engine.sv
// matrix_scalar_engine: applies mul/add/sub/pass between a scalar and every valid element of an r x c matrix.
// Latency: done pulses ceil(r*c/LANES) cycles after the accepting edge, LANES elements per cycle.
// Backpressure: none; start is sampled only in IDLE and is dropped while RUN/DONE (no queueing).
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op, r, c   job request, opcode (00 mul, 01 add, 10 sub, 11 pass), operand dims
//   scalar, data_in   scalar operand and compact row-major matrix (element k at [k*W +: W])
//   busy, done, err   RUN indicator, one-cycle completion pulse, one-cycle bad-dims pulse
//   ovf               sticky over/underflow of the last job, valid with done
//   r_out, c_out      dims of the last accepted job
//   data_out          result, same layout as data_in; elements k >= r*c stay 0
//
// Build option: define MSCALAR_SAT_EN for saturating results; otherwise results wrap mod 2^W.
module matrix_scalar_engine #(
    parameter int DATA_WIDTH = 9,
    parameter int MAX_DIM    = 5,
    parameter int LANES      = 5
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [1:0]                               op,
    input  logic [2:0]                               r,
    input  logic [2:0]                               c,
    input  logic [DATA_WIDTH-1:0]                    scalar,
    input  logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0]    data_in,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err,
    output logic                                     ovf,
    output logic [2:0]                               r_out,
    output logic [2:0]                               c_out,
    output logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0]    data_out
);
    localparam int W     = DATA_WIDTH;
    localparam int NELEM = MAX_DIM * MAX_DIM;
    localparam int AW    = (NELEM > 1) ? $clog2(NELEM) : 1;
    // idx can run up to LANES past the last valid element before the job ends
    localparam int IDXW  = $clog2(NELEM + LANES + 1);
    localparam logic [IDXW-1:0] LANES_I   = IDXW'(LANES);
    localparam logic [2:0]      MAX_DIM_3 = 3'(MAX_DIM);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state;

    // job snapshot, so the inputs may change freely after acceptance
    logic [W-1:0]    snap_elem [NELEM];
    logic [W-1:0]    snap_scalar;
    logic [1:0]      snap_op;
    logic [IDXW-1:0] n_elem;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    res_mem [NELEM];

    logic            dims_ok;
    logic            last_beat;
    logic            run_ovf;
    logic [IDXW-1:0] lane_k    [LANES];
    logic [AW-1:0]   lane_a    [LANES];
    logic            lane_wr   [LANES];
    logic [W-1:0]    lane_e    [LANES];
    logic [2*W-1:0]  lane_prod [LANES];
    logic [W:0]      lane_sum  [LANES];
    logic [W-1:0]    lane_dif  [LANES];
    logic [W-1:0]    lane_res  [LANES];
    logic            lane_ovf  [LANES];

    assign dims_ok   = (r != 3'd0) && (c != 3'd0) && (r <= MAX_DIM_3) && (c <= MAX_DIM_3);
    assign last_beat = ({1'b0, idx} + {1'b0, LANES_I}) >= {1'b0, n_elem};

    always_comb begin
        run_ovf = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_k[l]    = idx + IDXW'(l);
            lane_a[l]    = lane_k[l][AW-1:0];
            lane_wr[l]   = lane_k[l] < n_elem;
            // lanes past the end of the matrix read as 0 and are never written
            lane_e[l]    = lane_wr[l] ? snap_elem[lane_a[l]] : '0;
            lane_prod[l] = {{W{1'b0}}, lane_e[l]} * {{W{1'b0}}, snap_scalar};
            lane_sum[l]  = {1'b0, lane_e[l]} + {1'b0, snap_scalar};
            lane_dif[l]  = lane_e[l] - snap_scalar;
            lane_res[l]  = lane_e[l];
            lane_ovf[l]  = 1'b0;
            case (snap_op)
                OP_MUL: begin
                    lane_ovf[l] = |lane_prod[l][2*W-1:W];
`ifdef MSCALAR_SAT_EN
                    lane_res[l] = lane_ovf[l] ? {W{1'b1}} : lane_prod[l][W-1:0];
`else
                    lane_res[l] = lane_prod[l][W-1:0];
`endif
                end
                OP_ADD: begin
                    lane_ovf[l] = lane_sum[l][W];
`ifdef MSCALAR_SAT_EN
                    lane_res[l] = lane_ovf[l] ? {W{1'b1}} : lane_sum[l][W-1:0];
`else
                    lane_res[l] = lane_sum[l][W-1:0];
`endif
                end
                OP_SUB: begin
                    lane_ovf[l] = lane_e[l] < snap_scalar;
`ifdef MSCALAR_SAT_EN
                    lane_res[l] = lane_ovf[l] ? {W{1'b0}} : lane_dif[l];
`else
                    lane_res[l] = lane_dif[l];
`endif
                end
                default: begin
                    lane_res[l] = lane_e[l];
                end
            endcase
            run_ovf = run_ovf | (lane_wr[l] & lane_ovf[l]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ovf         <= 1'b0;
            r_out       <= 3'd0;
            c_out       <= 3'd0;
            idx         <= '0;
            n_elem      <= '0;
            snap_scalar <= '0;
            snap_op     <= 2'b00;
            for (int k = 0; k < NELEM; k++) begin
                snap_elem[k] <= '0;
                res_mem[k]   <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            for (int k = 0; k < NELEM; k++) begin
                                snap_elem[k] <= data_in[k*W +: W];
                                res_mem[k]   <= '0;
                            end
                            snap_scalar <= scalar;
                            snap_op     <= op;
                            r_out       <= r;
                            c_out       <= c;
                            n_elem      <= IDXW'({3'b000, r} * {3'b000, c});
                            idx         <= '0;
                            ovf         <= 1'b0;
                            busy        <= 1'b1;
                            state       <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_wr[l]) begin
                            res_mem[lane_a[l]] <= lane_res[l];
                        end
                    end
                    ovf <= ovf | run_ovf;
                    idx <= idx + LANES_I;
                    if (last_beat) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NELEM; g++) begin : g_flat
        assign data_out[g*W +: W] = res_mem[g];
    end

endmodule
